// File: rtl/ifu_pkg.sv
// Shared types and sizing for the IFU instruction-cache controller.
package ifu_pkg;
    localparam int WAYS_NUM = 16;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = ADDR_W - OFFSET_W;
    localparam int WAY_W    = $clog2(WAYS_NUM);

    typedef logic [TAG_W-1:0] t_tag;
    typedef logic [WAY_W-1:0] t_way;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP
    } t_ifu_ctrl_state;

    typedef struct packed {
        logic update_tree;
        logic update_counter;
    } t_cache_ctrl2_plru;
endpackage

// File: rtl/ifu_tag_array.sv
// Fully-associative tag/valid store with parallel lookup, single write port and flush.
module ifu_tag_array
    import ifu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  t_tag lookup_tag,
    output logic hit,
    output t_way hit_way,
    input  logic wr_en,
    input  t_way wr_way,
    input  t_tag wr_tag,
    input  logic flush
);
    t_tag                tags [WAYS_NUM];
    logic [WAYS_NUM-1:0] valid;
    logic [WAYS_NUM-1:0] match;

    always_ff @(posedge clk) begin
        if (!rst)
            valid <= '0;
        else if (flush)
            valid <= '0;
        else if (wr_en)
            valid[wr_way] <= 1'b1;
        if (wr_en)
            tags[wr_way] <= wr_tag;
    end

    for (genvar i = 0; i < WAYS_NUM; i++) begin : g_cmp
        assign match[i] = valid[i] && (tags[i] == lookup_tag);
    end

    assign hit = |match;

    // Matches are one-hot, so OR-ing the indices is a valid encoder.
    always_comb begin
        hit_way = '0;
        for (int i = 0; i < WAYS_NUM; i++)
            if (match[i]) hit_way = hit_way | t_way'(i);
    end

    a_one_match: assert property (@(posedge clk) disable iff (!rst) $onehot0(match));
endmodule

// File: rtl/ifu_cache_ctrl.sv
// Sequencing FSM for the IFU fully-associative I-cache: lookup, miss fetch, fill, respond.
module ifu_cache_ctrl
    import ifu_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      req_addr,
    output logic                   rsp_valid,
    output logic                   rsp_hit,
    output logic [WAY_W-1:0]       data_rd_way,
    output logic                   data_wr_en,
    output logic [WAY_W-1:0]       data_wr_way,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_W-1:0]      mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic                   flush,
    output t_cache_ctrl2_plru      cache_ctrl2_plru,
    output logic                   cache_miss,
    output logic [WAY_W-1:0]       hit_cl,
    input  logic [WAY_W-1:0]       evicted_cl
);
    t_ifu_ctrl_state state, state_nxt;
    t_tag            tag_q;
    t_way            victim_q;
    logic            flush_pend;
    logic            hit;
    t_way            hit_way;
    logic            flush_do;
    logic            accept;

    assign flush_do = (state == IDLE) && (flush || flush_pend);
    assign accept   = (state == IDLE) && !flush_do && req_valid;

    ifu_tag_array u_tags (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (tag_q),
        .hit        (hit),
        .hit_way    (hit_way),
        .wr_en      (state == FILL),
        .wr_way     (victim_q),
        .wr_tag     (tag_q),
        .flush      (flush_do)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            tag_q      <= '0;
            victim_q   <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept)
                tag_q <= req_addr[ADDR_W-1:OFFSET_W];
            if (state == LOOKUP && !hit)
                victim_q <= evicted_cl;
            // A flush seen mid-transaction waits for the first IDLE cycle.
            if (state == IDLE)
                flush_pend <= 1'b0;
            else if (flush)
                flush_pend <= 1'b1;
        end
    end

    assign mem_req_addr = {tag_q, {OFFSET_W{1'b0}}};
    assign data_wr_way  = victim_q;
    assign req_ready    = (state == IDLE) && !flush_do;

    always_comb begin
        state_nxt        = state;
        rsp_valid        = 1'b0;
        rsp_hit          = 1'b0;
        data_rd_way      = victim_q;
        data_wr_en       = 1'b0;
        mem_req_valid    = 1'b0;
        cache_ctrl2_plru = '0;
        cache_miss       = 1'b0;
        hit_cl           = '0;
        case (state)
            IDLE: if (accept) state_nxt = LOOKUP;
            LOOKUP: begin
                if (hit) begin
                    rsp_valid                    = 1'b1;
                    rsp_hit                      = 1'b1;
                    data_rd_way                  = hit_way;
                    hit_cl                       = hit_way;
                    cache_ctrl2_plru.update_tree = 1'b1;
                    state_nxt                    = IDLE;
                end else begin
                    cache_miss = 1'b1;
                    state_nxt  = MISS_REQ;
                end
            end
            MISS_REQ: begin
                cache_miss    = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_nxt = MISS_WAIT;
            end
            MISS_WAIT: begin
                cache_miss = 1'b1;
                if (mem_rsp_valid) state_nxt = FILL;
            end
            FILL: begin
                data_wr_en       = 1'b1;
                cache_miss       = 1'b1;
                cache_ctrl2_plru = '{update_tree: 1'b1, update_counter: 1'b1};
                state_nxt        = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ifu_cache_ctrl.sv
// Scoreboard bench for ifu_cache_ctrl with a behavioural cache model and an LRU-style plru stand-in.
module tb_ifu_cache_ctrl;
    import ifu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic rsp_valid, rsp_hit;
    t_way data_rd_way, data_wr_way, hit_cl, evicted_cl;
    logic data_wr_en, mem_req_valid, mem_req_ready, mem_rsp_valid, flush, cache_miss;
    logic [ADDR_W-1:0] mem_req_addr;
    t_cache_ctrl2_plru cache_ctrl2_plru;

    always #5 clk = ~clk;

    ifu_cache_ctrl dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .data_rd_way(data_rd_way),
        .data_wr_en(data_wr_en), .data_wr_way(data_wr_way), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .flush(flush), .cache_ctrl2_plru(cache_ctrl2_plru), .cache_miss(cache_miss),
        .hit_cl(hit_cl), .evicted_cl(evicted_cl)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bad(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not match expectation", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // plru stand-in: allocate ways in order until full, then least-recently-touched way.
    t_way        pl_cnt;
    bit          pl_full;
    int unsigned pl_stamp [WAYS_NUM];
    int unsigned pl_time;
    t_way        pl_lru;
    int unsigned pl_best;

    always @(posedge clk) begin
        if (!rst) begin
            pl_cnt  <= '0;
            pl_full <= 1'b0;
            pl_time <= 0;
            for (int i = 0; i < WAYS_NUM; i++) pl_stamp[i] <= 0;
        end else begin
            if (cache_ctrl2_plru.update_tree) begin
                pl_time <= pl_time + 1;
                pl_stamp[cache_miss ? evicted_cl : hit_cl] <= pl_time + 1;
            end
            if (cache_ctrl2_plru.update_counter) begin
                if (pl_cnt == t_way'(WAYS_NUM - 1)) pl_full <= 1'b1;
                else pl_cnt <= pl_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        pl_lru  = '0;
        pl_best = pl_stamp[0];
        for (int i = 1; i < WAYS_NUM; i++)
            if (pl_stamp[i] < pl_best) begin
                pl_best = pl_stamp[i];
                pl_lru  = t_way'(i);
            end
        evicted_cl = pl_full ? pl_lru : pl_cnt;
    end

    // Reference cache contents and expectation queues.
    t_tag m_tag   [WAYS_NUM];
    bit   m_valid [WAYS_NUM];
    logic [WAY_W:0]    exp_rsp [$];
    logic [ADDR_W-1:0] exp_mem [$];
    t_way              exp_wr  [$];

    task automatic model_clear();
        for (int i = 0; i < WAYS_NUM; i++) m_valid[i] = 1'b0;
    endtask

    logic [WAY_W:0] me;
    always @(negedge clk) begin
        if (rst) begin
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) bad("rsp_unexpected");
                else begin
                    me = exp_rsp.pop_front();
                    chk("rsp", {rsp_hit, data_rd_way}, me);
                    if (me[WAY_W])
                        chk("hit_ctx", {hit_cl, cache_ctrl2_plru.update_tree, cache_miss},
                            {me[WAY_W-1:0], 1'b1, 1'b0});
                end
            end
            if (data_wr_en) begin
                if (exp_wr.size() == 0) bad("wr_unexpected");
                else chk("fill", {data_wr_way, cache_ctrl2_plru, cache_miss},
                         {exp_wr.pop_front(), 2'b11, 1'b1});
            end
            if (mem_req_valid && mem_req_ready) begin
                if (exp_mem.size() == 0) bad("mem_unexpected");
                else chk("mem_addr", mem_req_addr, exp_mem.pop_front());
            end
        end
    end

    localparam logic [10:0] RST_VEC = {1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0};

    function automatic logic [10:0] out_vec();
        return {req_ready, rsp_valid, data_wr_en, mem_req_valid, cache_ctrl2_plru, cache_miss, hit_cl};
    endfunction

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) step();
        chk("reset_outputs", out_vec(), RST_VEC);
        model_clear();
        rst = 1'b1;
        step();
    endtask

    task automatic do_flush();
        flush = 1'b1;
        #1;
        chk("flush_ready", req_ready, 1'b0);
        step();
        flush = 1'b0;
        model_clear();
    endtask

    task automatic do_req(input logic [ADDR_W-1:0] a, input int bp, input bit fl, input bit rs);
        t_tag tg;
        bit   hit;
        t_way w;
        int   n;
        tg  = a[ADDR_W-1:OFFSET_W];
        hit = 1'b0;
        w   = '0;
        for (int i = 0; i < WAYS_NUM; i++)
            if (m_valid[i] && m_tag[i] == tg) begin
                hit = 1'b1;
                w   = t_way'(i);
            end
        if (hit) exp_rsp.push_back({1'b1, w});
        else begin
            w = evicted_cl;
            exp_mem.push_back({tg, {OFFSET_W{1'b0}}});
            exp_wr.push_back(w);
            exp_rsp.push_back({1'b0, w});
            m_tag[w]   = tg;
            m_valid[w] = 1'b1;
        end
        n = 0;
        while (!req_ready && n < 20) begin step(); n++; end
        if (n == 20) bad("req_ready_timeout");
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
        if (hit) begin
            chk("hit_latency", rsp_valid, 1'b1);
            step();
            return;
        end
        n = 0;
        while (!mem_req_valid && n < 20) begin step(); n++; end
        if (n == 20) begin bad("mem_req_timeout"); return; end
        for (int k = 0; k < bp; k++) begin
            chk("backpressure", {mem_req_valid, req_ready, mem_req_addr},
                {1'b1, 1'b0, tg, {OFFSET_W{1'b0}}});
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        repeat ($urandom_range(0, 3)) step();
        if (rs) begin
            rst = 1'b0;
            step();
            chk("midmiss_reset", out_vec(), RST_VEC);
            rst = 1'b1;
            if (exp_wr.size() != 0) void'(exp_wr.pop_back());
            if (exp_rsp.size() != 0) void'(exp_rsp.pop_back());
            model_clear();
            step();
            mem_rsp_valid = 1'b1;
            step();
            mem_rsp_valid = 1'b0;
            repeat (4) step();
            return;
        end
        if (fl) begin
            flush = 1'b1;
            step();
            flush = 1'b0;
            model_clear();
        end
        mem_rsp_valid = 1'b1;
        step();
        mem_rsp_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin step(); n++; end
        if (n == 10) bad("fill_rsp_timeout");
        step();
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_addr = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; flush = 1'b0;
        model_clear();
        apply_reset();

        // cold miss then hit on the same line
        do_req(32'h0000_1000, 0, 0, 0);
        do_req(32'h0000_1004, 0, 0, 0);

        // sixteen fills in order, touch ways 1..15, then evict way 0
        apply_reset();
        for (int i = 0; i < 16; i++) do_req(32'(i) << 12, 0, 0, 0);
        for (int i = 1; i < 16; i++) do_req((32'(i) << 12) + 32'h8, 0, 0, 0);
        do_req(32'h0001_0000, 0, 0, 0);

        do_req(32'h0002_0000, 5, 0, 0);

        // flush while waiting on memory, then the same line misses again
        do_req(32'h0003_0000, 0, 1, 0);
        do_req(32'h0003_0000, 0, 0, 0);

        do_req(32'h0004_0000, 0, 0, 1);
        do_req(32'h0004_0000, 0, 0, 0);

        for (int t = 0; t < 250; t++) begin
            if ($urandom_range(0, 19) == 0) do_flush();
            do_req(32'h8000_0000 + (32'($urandom_range(0, 23)) << 4) + 32'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 14) == 0, 1'b0);
        end

        repeat (4) step();
        chk("scoreboard_drained", {32'(exp_rsp.size()), 32'(exp_wr.size() + exp_mem.size())}, 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
